// File: rtl/branch_predictor_gshare_if.sv
// ============================================================================
// branch_predictor_gshare_if : branch-outcome type plus decode/execute port set
// Revision 1.0
// ============================================================================
`default_nettype none

package mips_core_pkg;
  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;
endpackage

interface branch_predictor_gshare_if #(
  parameter int ADDR_WIDTH = 32
);
  import mips_core_pkg::*;

  logic                  i_req_valid;
  logic [ADDR_WIDTH-1:0] i_req_pc;
  logic [ADDR_WIDTH-1:0] i_req_target;
  BranchOutcome          o_req_prediction;

  logic                  i_fb_valid;
  logic [ADDR_WIDTH-1:0] i_fb_pc;
  BranchOutcome          i_fb_prediction;
  BranchOutcome          i_fb_outcome;

  logic                  o_init_done;

  modport master (
    output i_req_valid, i_req_pc, i_req_target,
    output i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome,
    input  o_req_prediction, o_init_done
  );

  modport slave (
    input  i_req_valid, i_req_pc, i_req_target,
    input  i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome,
    output o_req_prediction, o_init_done
  );
endinterface

`default_nettype wire

// File: rtl/branch_predictor_gshare.sv
// ============================================================================
// branch_predictor_gshare : gshare direction predictor, PC xor global history
// Revision 1.0
// ============================================================================
`default_nettype none

module branch_predictor_gshare
  import mips_core_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 8,
  parameter int HIST_BITS  = 8,
  parameter int CTR_BITS   = 2,
  parameter int PC_SHIFT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  branch_predictor_gshare_if.slave bp
);

  localparam int                    ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0]   WNT     = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]   CMAX    = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]   CZERO   = '0;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state;
  logic [INDEX_BITS-1:0] init_ptr;
  logic [HIST_BITS-1:0]  spec_ghr;
  logic [HIST_BITS-1:0]  ret_ghr;
  logic [CTR_BITS-1:0]   ctr_table [ENTRIES];

  logic                  running;
  logic [INDEX_BITS-1:0] req_idx;
  logic [INDEX_BITS-1:0] fb_idx;
  logic [CTR_BITS-1:0]   req_ctr;
  logic [CTR_BITS-1:0]   fb_ctr;
  logic [CTR_BITS-1:0]   fb_ctr_next;
  logic                  req_taken;
  logic                  fb_taken;
  logic                  mispredict;
  logic [HIST_BITS-1:0]  spec_shifted;
  logic [HIST_BITS-1:0]  ret_shifted;

  logic                  wr_en;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [CTR_BITS-1:0]   wr_data;

  // Only the index slice of the PCs matters; the target is carried for port compatibility.
  logic unused_bits;
  assign unused_bits = ^{bp.i_req_target, bp.i_req_pc, bp.i_fb_pc};

  assign running = (state == ST_RUN);

  assign req_idx = bp.i_req_pc[PC_SHIFT +: INDEX_BITS] ^ INDEX_BITS'(spec_ghr);
  assign fb_idx  = bp.i_fb_pc[PC_SHIFT +: INDEX_BITS]  ^ INDEX_BITS'(ret_ghr);

  assign req_ctr   = ctr_table[req_idx];
  assign fb_ctr    = ctr_table[fb_idx];
  assign req_taken = running && req_ctr[CTR_BITS-1];

  assign fb_taken   = (bp.i_fb_outcome == TAKEN);
  assign mispredict = bp.i_fb_valid && (bp.i_fb_prediction != bp.i_fb_outcome);

  always_comb begin
    fb_ctr_next = fb_ctr;
    if (fb_taken) begin
      if (fb_ctr != CMAX) begin
        fb_ctr_next = fb_ctr + CTR_BITS'(1);
      end
    end else begin
      if (fb_ctr != CZERO) begin
        fb_ctr_next = fb_ctr - CTR_BITS'(1);
      end
    end
  end

  generate
    if (HIST_BITS == 1) begin : g_hist_single
      assign spec_shifted = req_taken;
      assign ret_shifted  = fb_taken;
    end else begin : g_hist_multi
      assign spec_shifted = {spec_ghr[HIST_BITS-2:0], req_taken};
      assign ret_shifted  = {ret_ghr[HIST_BITS-2:0], fb_taken};
    end
  endgenerate

  // Single write port: INIT clearing and RUN training never overlap.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = fb_idx;
    wr_data = fb_ctr_next;
    if (!rst) begin
      if (state == ST_INIT) begin
        wr_en   = 1'b1;
        wr_idx  = init_ptr;
        wr_data = WNT;
      end else if (bp.i_fb_valid) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ctr_table[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      spec_ghr <= '0;
      ret_ghr  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + INDEX_BITS'(1);
          if (init_ptr == {INDEX_BITS{1'b1}}) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A mispredict flushes the path, so the repair overrides any same-cycle request.
          if (mispredict) begin
            spec_ghr <= ret_shifted;
          end else if (bp.i_req_valid) begin
            spec_ghr <= spec_shifted;
          end
          if (bp.i_fb_valid) begin
            ret_ghr <= ret_shifted;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bp.o_req_prediction = req_taken ? TAKEN : NOT_TAKEN;
  assign bp.o_init_done      = running;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
// ============================================================================
// tb_branch_predictor_gshare : three parameterisations driven in lockstep,
// each checked against its own behavioural model through a scoreboard.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_branch_predictor_gshare;
  import mips_core_pkg::*;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_gshare_if #(.ADDR_WIDTH(32)) bp0();
  branch_predictor_gshare_if #(.ADDR_WIDTH(32)) bp1();
  branch_predictor_gshare_if #(.ADDR_WIDTH(32)) bp2();

  branch_predictor_gshare #(.ADDR_WIDTH(32), .INDEX_BITS(8), .HIST_BITS(8), .CTR_BITS(2), .PC_SHIFT(2))
    u_dut0 (.clk(clk), .rst(rst), .bp(bp0.slave));
  branch_predictor_gshare #(.ADDR_WIDTH(32), .INDEX_BITS(6), .HIST_BITS(4), .CTR_BITS(3), .PC_SHIFT(2))
    u_dut1 (.clk(clk), .rst(rst), .bp(bp1.slave));
  branch_predictor_gshare #(.ADDR_WIDTH(32), .INDEX_BITS(4), .HIST_BITS(1), .CTR_BITS(2), .PC_SHIFT(2))
    u_dut2 (.clk(clk), .rst(rst), .bp(bp2.slave));

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ib_of(input int d);
    case (d)
      0: return 8;
      1: return 6;
      default: return 4;
    endcase
  endfunction

  function automatic int hb_of(input int d);
    case (d)
      0: return 8;
      1: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int cb_of(input int d);
    return (d == 1) ? 3 : 2;
  endfunction

  // Behavioural reference model, one copy per parameterisation.
  int unsigned m_tab  [NDUT][4096];
  int unsigned m_spec [NDUT];
  int unsigned m_ret  [NDUT];
  int unsigned m_ptr  [NDUT];
  bit          m_done [NDUT];
  bit          m_known = 1'b0;

  function automatic int unsigned midx(input int d, input logic [31:0] pc, input int unsigned h);
    int unsigned n;
    n = 1 << ib_of(d);
    return ((int'(pc) >> 2) & (n - 1)) ^ h;
  endfunction

  function automatic bit mpred(input int d, input logic [31:0] pc);
    int unsigned c;
    if (!m_done[d]) return 1'b0;
    c = m_tab[d][midx(d, pc, m_spec[d])];
    return ((c >> (cb_of(d) - 1)) & 1) == 1;
  endfunction

  function automatic int unsigned mshift(input int d, input int unsigned h, input bit t);
    return ((h << 1) | int'(t)) & ((1 << hb_of(d)) - 1);
  endfunction

  task automatic model_edge(input int d, input bit r, input bit rv, input logic [31:0] rpc,
                            input bit fv, input logic [31:0] fpc, input bit fp, input bit fo);
    bit          p;
    int unsigned ns, nr, e, c, cmax;
    cmax = (1 << cb_of(d)) - 1;
    if (r) begin
      m_done[d] = 1'b0;
      m_ptr[d]  = 0;
      m_spec[d] = 0;
      m_ret[d]  = 0;
      for (int i = 0; i < (1 << ib_of(d)); i++) m_tab[d][i] = (1 << (cb_of(d) - 1)) - 1;
    end else if (!m_done[d]) begin
      m_ptr[d]++;
      if (m_ptr[d] == (1 << ib_of(d))) m_done[d] = 1'b1;
    end else begin
      p  = mpred(d, rpc);
      ns = m_spec[d];
      if (rv) ns = mshift(d, m_spec[d], p);
      if (fv) begin
        e = midx(d, fpc, m_ret[d]);
        c = m_tab[d][e];
        if (fo) c = (c == cmax) ? c : c + 1;
        else    c = (c == 0) ? c : c - 1;
        m_tab[d][e] = c;
        nr = mshift(d, m_ret[d], fo);
        m_ret[d] = nr;
        if (fp != fo) ns = nr;
      end
      m_spec[d] = ns;
    end
  endtask

  typedef struct {
    string       tag;
    int          d;
    logic [31:0] pred;
    logic [31:0] done;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] act_pred(input int d);
    logic p;
    case (d)
      0: p = bp0.o_req_prediction;
      1: p = bp1.o_req_prediction;
      default: p = bp2.o_req_prediction;
    endcase
    return {31'd0, p};
  endfunction

  function automatic logic [31:0] act_done(input int d);
    logic p;
    case (d)
      0: p = bp0.o_init_done;
      1: p = bp1.o_init_done;
      default: p = bp2.o_init_done;
    endcase
    return {31'd0, p};
  endfunction

  task automatic drive_all(input bit rv, input logic [31:0] rpc, input bit fv,
                           input logic [31:0] fpc, input bit fp, input bit fo);
    BranchOutcome pe, oe;
    pe = fp ? TAKEN : NOT_TAKEN;
    oe = fo ? TAKEN : NOT_TAKEN;
    bp0.i_req_valid = rv; bp0.i_req_pc = rpc; bp0.i_req_target = rpc + 32'h40;
    bp0.i_fb_valid = fv; bp0.i_fb_pc = fpc; bp0.i_fb_prediction = pe; bp0.i_fb_outcome = oe;
    bp1.i_req_valid = rv; bp1.i_req_pc = rpc; bp1.i_req_target = rpc + 32'h40;
    bp1.i_fb_valid = fv; bp1.i_fb_pc = fpc; bp1.i_fb_prediction = pe; bp1.i_fb_outcome = oe;
    bp2.i_req_valid = rv; bp2.i_req_pc = rpc; bp2.i_req_target = rpc + 32'h40;
    bp2.i_fb_valid = fv; bp2.i_fb_pc = fpc; bp2.i_fb_prediction = pe; bp2.i_fb_outcome = oe;
  endtask

  // One clock: drive on the falling edge, score just after, advance the model on the rising edge.
  task automatic cycle(input bit r, input bit rv, input logic [31:0] rpc, input bit fv,
                       input logic [31:0] fpc, input bit fp, input bit fo);
    exp_t e;
    @(negedge clk);
    rst = r;
    drive_all(rv, rpc, fv, fpc, fp, fo);
    if (m_known) begin
      for (int d = 0; d < NDUT; d++) begin
        sb.push_back('{$sformatf("d%0d@%0d", d, cyc), d, {31'd0, mpred(d, rpc)}, {31'd0, m_done[d]}});
      end
    end
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".pred"}, act_pred(e.d), e.pred);
      check({e.tag, ".done"}, act_done(e.d), e.done);
    end
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) model_edge(d, r, rv, rpc, fv, fpc, fp, fo);
    if (r) m_known = 1'b1;
    cyc++;
  endtask

  task automatic idle(input logic [31:0] pc);
    cycle(1'b0, 1'b0, pc, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic req(input logic [31:0] pc);
    cycle(1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic fb(input logic [31:0] pc, input bit fp, input bit fo);
    cycle(1'b0, 1'b0, pc, 1'b1, pc, fp, fo);
  endtask

  initial begin
    logic [31:0] pcs [5];
    pcs[0] = 32'h400; pcs[1] = 32'h404; pcs[2] = 32'h100; pcs[3] = 32'h200; pcs[4] = 32'h3fc;
    drive_all(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset, then the init sweep with requests and feedback that must be ignored.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) cycle(1'b0, 1'b1, 32'(i * 4), 1'b1, 32'h400, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) idle(32'(i * 4));

    // pc 0x400 resolved taken three times, each mispredicted, then saturation and back down.
    for (int i = 0; i < 3; i++) begin
      req(32'h400);
      fb(32'h400, 1'b0, 1'b1);
    end
    for (int i = 0; i < 8; i++) fb(32'h400, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) req(32'h400);
    for (int i = 0; i < 10; i++) fb(32'h400, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) req(32'h400);

    // Mispredict repair coinciding with a request; then correct feedback with a request.
    req(32'h100);
    cycle(1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0);
    req(32'h100);
    cycle(1'b0, 1'b1, 32'h104, 1'b1, 32'h100, 1'b0, 1'b0);
    req(32'h104);

    // Mixed traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), pcs[$urandom_range(0, 4)],
            1'($urandom_range(0, 1)), pcs[$urandom_range(0, 4)],
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end

    // Train hot entries, then reset mid-run and re-run the full init.
    for (int i = 0; i < 6; i++) fb(32'h400, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) fb(32'h200, 1'b1, 1'b1);
    req(32'h400);
    cycle(1'b1, 1'b1, 32'h400, 1'b1, 32'h400, 1'b1, 1'b1);
    for (int i = 0; i < 258; i++) idle(32'(i * 4));
    for (int i = 0; i < 256; i++) idle(32'(i * 4));

    // Read-before-write on a shared index, correct then mispredicted variants.
    cycle(1'b0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 1'b1);
    req(32'h200);
    req(32'h204);
    idle(32'h200);
    cycle(1'b0, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 1'b1);
    req(32'h300);
    req(32'h304);
    for (int i = 0; i < 64; i++) idle(32'(i * 4));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised successor to the single-counter 2-bit predictor: a gshare direction predictor with a table of saturating counters, indexed by PC XOR global history.
- Sits behind branch_controller, on the same request (decode) and feedback (execute) port set.
- Keeps a speculative history, updated at predict time, and a retired history, updated at feedback time. A mispredict repairs the speculative history.
- After reset, an init FSM clears the table.

Parameters:
- ADDR_WIDTH, 32, PC width.
- INDEX_BITS, 8, log2 of counter-table entries. Range 2..12.
- HIST_BITS, 8, global history length. Must be 1..INDEX_BITS.
- CTR_BITS, 2, saturating counter width. Range 1..4.
- PC_SHIFT, 2, PC bits dropped before indexing (word-aligned).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_req_valid  in  1  conditional-branch prediction request (decode).
- i_req_pc  in  ADDR_WIDTH  PC of requesting branch.
- i_req_target  in  ADDR_WIDTH  decoded target; unused; kept for interface compatibility.
- o_req_prediction  out  mips_core_pkg::BranchOutcome  predicted direction, combinational from the current state.
- i_fb_valid  in  1  resolved conditional branch (execute).
- i_fb_pc  in  ADDR_WIDTH  PC of resolved branch.
- i_fb_prediction  in  BranchOutcome  prediction originally given.
- i_fb_outcome  in  BranchOutcome  actual outcome.
- o_init_done  out  1  table initialised; predictor active.

Behaviour:
- Definitions:
  - WNT = 2^(CTR_BITS-1)-1, weakly not-taken.
  - CMAX = 2^CTR_BITS-1.
  - idx(pc,h) = pc[PC_SHIFT +: INDEX_BITS] XOR zero_extend(h, INDEX_BITS). History sits in the low bits.
- Histories:
  - spec_ghr and ret_ghr are HIST_BITS wide.
  - Shift-in rule: ghr <= {ghr[HIST_BITS-2:0], taken}, with newest outcome in bit 0.
  - When HIST_BITS=1: ghr <= taken.
- FSM states: INIT, RUN.
- Reset (rst=1 at a clock edge):
  - State goes to INIT; init pointer goes to 0.
  - spec_ghr and ret_ghr go to 0.
  - o_init_done goes to 0.
  - Reset mid-operation aborts everything and restarts INIT.
- INIT:
  - Each cycle writes WNT to table[ptr], then ptr increments.
  - After writing entry 2^INDEX_BITS-1, the next state is RUN and o_init_done=1.
  - Init takes exactly 2^INDEX_BITS cycles after reset deasserts.
  - o_req_prediction=NOT_TAKEN.
  - Requests and feedback are ignored: no history or table change.
- RUN, prediction:
  - o_req_prediction = TAKEN iff table[idx(i_req_pc, spec_ghr)][CTR_BITS-1]=1. Zero-cycle latency.
  - When i_req_valid=1, spec_ghr shifts in the predicted direction at the clock edge.
  - When i_req_valid=0, o_req_prediction is still driven but no state changes.
- RUN, feedback (i_fb_valid=1):
  - Update entry: e=idx(i_fb_pc, ret_ghr). The pipeline resolves in order, so ret_ghr equals the history used at prediction.
  - Outcome TAKEN: counter increments, saturating at CMAX.
  - Outcome NOT_TAKEN: counter decrements, saturating at 0.
  - ret_ghr shifts in the outcome.
  - Mispredict (i_fb_prediction != i_fb_outcome): spec_ghr <= shifted ret_ghr (the same value ret_ghr takes).
  - Wrong-path requests never receive feedback.
- Simultaneous events:
  - Request and feedback to the same entry in one cycle: the prediction uses the pre-update counter (read-before-write).
  - Mispredict feedback plus valid request in one cycle: repair wins and the request's speculative shift is discarded. That request is on the flushed path.
  - Correct feedback plus valid request in one cycle: spec_ghr shifts with the request prediction; ret_ghr shifts with the outcome. The two are independent.
- Storage: table is plain registers or inferred RAM with an asynchronous read port; one write port suffices because INIT and RUN writes are exclusive.
- Widths: all counter arithmetic is CTR_BITS wide and must never wrap.
- Controller change: branch_controller instantiates this block with rst driven from ~rst_n.

Test Plan:
1. Reset, then hold rst=0, INDEX_BITS=8: o_init_done=0 for cycles 0..255 with predictions NOT_TAKEN. o_init_done=1 from cycle 256. Every entry reads 2'b01.
2. Branch pc=0x400 resolved TAKEN 3× (each predicted, fed back NOT_TAKEN, then TAKEN): ret_ghr=8'b00000111. The entries idx(0x400,0x00), idx(0x400,0x01) and idx(0x400,0x03) each reach 2'b10. The counter saturates at 2'b11 and never wraps to 0 after 5 more TAKENs at a fixed index (HIST_BITS=1 variant).
3. Request pc=0x100 with spec_ghr=0xA5 predicts TAKEN; spec_ghr becomes 0x4B. Next cycle, mispredict feedback (pred TAKEN, outcome NOT_TAKEN) with ret_ghr=0xA5 → spec_ghr=0x4A and ret_ghr=0x4A. A same-cycle valid request does not alter the 0x4A.
4. Same-cycle request and feedback on one index with counter=2'b01, outcome TAKEN: prediction is NOT_TAKEN this cycle. The next request to that index predicts TAKEN.
5. Assert rst mid-RUN after training several entries to 2'b11: INIT restarts and all entries return to 2'b01. Both histories become 0; o_init_done drops the next cycle.
6. CTR_BITS=3, HIST_BITS=4, INDEX_BITS=6: reset value is 3'b011; 64 init cycles. Predict TAKEN only at counter ≥ 4; saturation at 7 and 0.
